// File: rtl/morph_pkg.sv
// Shared constants and helpers for the binary morphology filter.
package morph_pkg;

  localparam logic MODE_ERODE  = 1'b0;
  localparam logic MODE_DILATE = 1'b1;

  // Legal parameter ranges for morph_filter
  localparam int IMG_W_MIN = 16;
  localparam int IMG_W_MAX = 2047;
  localparam int IMG_H_MIN = 16;
  localparam int IMG_H_MAX = 1023;
  localparam int K_MIN     = 2;
  localparam int K_MAX     = 7;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/morph_line_buf.sv
// One video line of 1-bit mask storage: synchronous write, asynchronous read
// at the same address, so a read during a write returns the previous line's bit.
module morph_line_buf #(
  parameter int DEPTH = 320,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wdata_i,
  output logic          rdata_o
);

  logic mem [DEPTH];

  // Write the incoming pixel into the line store
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/morph_filter.sv
// K x K binary erode/dilate on the render mask, driven by the VTC counters.
// The window is anchored bottom-right: the output for pixel (h,v) covers
// columns h-K+1..h and lines v-K+1..v, and appears one PCLK later.
module morph_filter
  import morph_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int K      = 4,
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              mode_i,
  input  logic [HCNT_W-1:0] VtcHCnt,
  input  logic [VCNT_W-1:0] VtcVCnt,
  input  logic              render_i,
  output logic              render_o
);

  localparam int NB    = K - 1;
  localparam int PTR_W = (clog2(NB) < 1) ? 1 : clog2(NB);
  localparam int AW    = clog2(IMG_W);

  if (IMG_W < IMG_W_MIN || IMG_W > IMG_W_MAX ||
      IMG_H < IMG_H_MIN || IMG_H > IMG_H_MAX ||
      K < K_MIN || K > K_MAX) begin : g_bad_param
    $error("morph_filter: parameter out of range");
  end

  logic                   active;
  logic                   frame_start;
  logic                   line_end;
  logic [AW-1:0]          addr;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       wr_sel;
  logic                   mode_q, mode_d;
  logic                   frame_ok_q, frame_ok_d;
  logic                   render_q, render_d;
  logic [K-1:0][K-2:0]    win_q, win_d;
  logic [NB-1:0]          rd;
  logic [K-1:0]           live;
  logic                   win_full;
  logic                   red_and, red_or;

  assign active      = (VtcHCnt < HCNT_W'(IMG_W)) && (VtcVCnt < VCNT_W'(IMG_H));
  assign frame_start = (VtcHCnt == '0) && (VtcVCnt == '0);
  assign line_end    = active && (VtcHCnt == HCNT_W'(IMG_W - 1));
  assign addr        = VtcHCnt[AW-1:0];
  // The frame-start pointer reset must already steer the (0,0) write and reads
  assign wr_sel      = frame_start ? '0 : wr_ptr_q;
  assign win_full    = (VtcHCnt >= HCNT_W'(K - 1)) && (VtcVCnt >= VCNT_W'(K - 1));

  for (genvar b = 0; b < NB; b++) begin : g_buf
    morph_line_buf #(
      .DEPTH (IMG_W),
      .AW    (AW)
    ) u_buf (
      .clk     (PCLK),
      .we_i    (active && !RST && (wr_sel == PTR_W'(b))),
      .addr_i  (addr),
      .wdata_i (render_i),
      .rdata_o (rd[b])
    );
  end

  // Live column: row 0 is the incoming pixel, row r is line v-r taken from
  // buffer (wr_sel - r) mod NB; the buffer being written yields line v-NB.
  always_comb begin
    live    = '0;
    live[0] = render_i;
    for (int r = 1; r < K; r++) begin
      for (int b = 0; b < NB; b++) begin
        if (((int'(wr_sel) + NB - r) % NB) == b) live[r] = rd[b];
      end
    end
  end

  // Next-state for pointer, mode latch, frame validity, window and output
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    mode_d     = mode_q;
    frame_ok_d = frame_ok_q;
    win_d      = win_q;
    render_d   = 1'b0;
    red_and    = (&live) & (&win_q);
    red_or     = (|live) | (|win_q);

    if (frame_start) begin
      wr_ptr_d   = '0;
      mode_d     = mode_i;
      frame_ok_d = 1'b1;
    end else if (line_end) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(NB - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (active) begin
      for (int r = 0; r < K; r++) begin
        win_d[r][0] = live[r];
        for (int c = 1; c < K - 1; c++) begin
          win_d[r][c] = (VtcHCnt == '0) ? 1'b0 : win_q[r][c-1];
        end
      end
    end

    if (active && frame_ok_q && win_full) begin
      render_d = (mode_q == MODE_DILATE) ? red_or : red_and;
    end
  end

  // State registers; reset clears all control and window state
  always_ff @(posedge PCLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      mode_q     <= MODE_ERODE;
      frame_ok_q <= 1'b0;
      win_q      <= '0;
      render_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      mode_q     <= mode_d;
      frame_ok_q <= frame_ok_d;
      win_q      <= win_d;
      render_q   <= render_d;
    end
  end

  assign render_o = render_q;

endmodule

// File: tb/tb_morph_filter.sv
// Directed bench for morph_filter: three instances (K=3, K=4, K=7) share the
// VTC counters and inputs; each frame checks one instance pixel by pixel.
module tb_morph_filter;

  localparam int W3 = 32;
  localparam int H3 = 24;
  localparam int W7 = 64;
  localparam int H7 = 32;
  localparam int HB = 4;
  localparam int VB = 2;

  logic        PCLK = 1'b0;
  logic        RST;
  logic        mode_i;
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic        render_i;
  logic        ro3, ro4, ro7;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 PCLK = ~PCLK;

  morph_filter #(.IMG_W(W3), .IMG_H(H3), .K(3), .HCNT_W(12), .VCNT_W(11)) u_k3 (
    .PCLK(PCLK), .RST(RST), .mode_i(mode_i), .VtcHCnt(hcnt), .VtcVCnt(vcnt),
    .render_i(render_i), .render_o(ro3));

  morph_filter #(.IMG_W(W3), .IMG_H(H3), .K(4), .HCNT_W(12), .VCNT_W(11)) u_k4 (
    .PCLK(PCLK), .RST(RST), .mode_i(mode_i), .VtcHCnt(hcnt), .VtcVCnt(vcnt),
    .render_i(render_i), .render_o(ro4));

  morph_filter #(.IMG_W(W7), .IMG_H(H7), .K(7), .HCNT_W(12), .VCNT_W(11)) u_k7 (
    .PCLK(PCLK), .RST(RST), .mode_i(mode_i), .VtcHCnt(hcnt), .VtcVCnt(vcnt),
    .render_i(render_i), .render_o(ro7));

  function automatic logic pick(input int sel);
    case (sel)
      3:       return ro3;
      4:       return ro4;
      default: return ro7;
    endcase
  endfunction

  function automatic logic inr(input int x, input int lo, input int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  task automatic check(input logic obs, input logic exp, input string tag,
                       input int h, input int v);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s h=%0d v=%0d: got %b expected %b", tag, h, v, obs, exp);
    end
  endtask

  // Stimulus per scenario: input pixel, mode and reset for counter (h,v)
  task automatic stim(input int scen, input int h, input int v,
                      output logic r, output logic m, output logic rs);
    r = 1'b0; m = 1'b0; rs = 1'b0;
    case (scen)
      0: r = 1'b1;
      1: begin r = (h == 10 && v == 8); m = 1'b1; end
      2: r = !(h == 20 && v == 12);
      3: begin r = (h == 5 && v == 15); m = (v > 10) || (v == 10 && h >= 16); end
      4: begin r = (h == 5 && v == 15); m = 1'b1; end
      5: begin r = 1'b1; rs = (v == 12) && (h == 10 || h == 11); end
      6: begin r = (h == 63 && v == 31); m = 1'b1; end
      default: m = 1'b1;
    endcase
  endtask

  // Expected output for the pixel presented at (h,v), hand-derived geometry
  function automatic logic expect_px(input int scen, input int h, input int v,
                                     input int w, input int hg);
    logic act;
    act = (h < w) && (v < hg);
    case (scen)
      0: return act && h >= 2 && v >= 2;
      1: return inr(h, 10, 12) && inr(v, 8, 10);
      2: return act && h >= 3 && v >= 3 && !(inr(h, 20, 23) && inr(v, 12, 15));
      3: return 1'b0;
      4: return inr(h, 5, 7) && inr(v, 15, 17);
      5: return act && h >= 2 && v >= 2 && (v < 12 || (v == 12 && h < 10));
      6: return (h == 63) && (v == 31);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_frame(input int sel, input int scen, input string tag);
    int w, hg;
    logic r, m, rs, e;
    w  = (sel == 7) ? W7 : W3;
    hg = (sel == 7) ? H7 : H3;
    for (int v = 0; v < hg + VB; v++) begin
      for (int h = 0; h < w + HB; h++) begin
        stim(scen, h, v, r, m, rs);
        e        = expect_px(scen, h, v, w, hg);
        hcnt     = 12'(h);
        vcnt     = 11'(v);
        render_i = r;
        mode_i   = m;
        RST      = rs;
        @(posedge PCLK);
        #1;
        check(pick(sel), e, tag, h, v);
      end
    end
  endtask

  initial begin
    RST      = 1'b1;
    mode_i   = 1'b1;
    hcnt     = 12'd100;
    vcnt     = 11'd100;
    render_i = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    check(ro3, 1'b0, "reset_k3", 100, 100);
    check(ro4, 1'b0, "reset_k4", 100, 100);
    check(ro7, 1'b0, "reset_k7", 100, 100);
    RST = 1'b0;

    run_frame(3, 0, "k3_erode_ones");
    run_frame(3, 1, "k3_dilate_dot");
    run_frame(4, 2, "k4_erode_hole");
    run_frame(3, 3, "mode_midframe");
    run_frame(3, 4, "mode_next_frame");
    run_frame(3, 5, "reset_midframe");
    run_frame(3, 0, "after_reset");
    run_frame(7, 6, "k7_corner_dot");
    run_frame(7, 7, "k7_no_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
